// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Groups the bus signals between the control unit, the arbiter and the RAM.
//   fetch side (IF, read-only): if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   load/store side (LS)      : ls_req, ls_we, ls_addr, ls_wdata
//                               -> ls_gnt, ls_rvalid, ls_rdata
//   RAM side                  : mem_addr, mem_write_en, mem_wdata <- mem_rdata
//
// Modports:
//   slave  - the arbiter's view (drives grants, responses and RAM pins)
//   master - the surrounding control unit / RAM view (the mirror image)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int REG_SIZE = 8
);

   // instruction-fetch requester
   logic                if_req;
   logic [REG_SIZE-1:0] if_addr;
   logic                if_gnt;
   logic                if_rvalid;
   logic [REG_SIZE-1:0] if_rdata;

   // load/store requester
   logic                ls_req;
   logic                ls_we;
   logic [REG_SIZE-1:0] ls_addr;
   logic [REG_SIZE-1:0] ls_wdata;
   logic                ls_gnt;
   logic                ls_rvalid;
   logic [REG_SIZE-1:0] ls_rdata;

   // single-port RAM
   logic [REG_SIZE-1:0] mem_addr;
   logic                mem_write_en;
   logic [REG_SIZE-1:0] mem_wdata;
   logic [REG_SIZE-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_addr, mem_write_en, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output ls_req, ls_we, ls_addr, ls_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_addr, mem_write_en, mem_wdata
   );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port core RAM between the instruction-fetch requester (IF,
// read-only) and the load/store requester (LS). One transaction is in flight at
// a time; the RAM returns read data RAM_LAT cycles after the address is shown.
//
// Parameters:
//   REG_SIZE - address and data width
//   RAM_LAT  - RAM read latency in cycles, legal range 1..4
//
// Ports:
//   CLK - rising-edge clock
//   RST - synchronous, active-high reset
//   bus - mem_arbiter_if.slave: request/grant/response for IF and LS, and the
//         RAM address / write-enable / data pins owned by this block
//
// Timing: a grant in cycle t (Mealy, from IDLE or RESP) gives rvalid in cycle
// t+RAM_LAT+1, so back-to-back transactions run every RAM_LAT+1 cycles with the
// next grant overlapping the previous response.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int REG_SIZE = 8,
   parameter int RAM_LAT  = 1
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // BUSY lasts RAM_LAT cycles; the counter runs 0 .. RAM_LAT-1.
   localparam logic [2:0] LAST_CNT = 3'(RAM_LAT - 1);

   state_t              state;
   state_t              state_nxt;

   logic                gnt_if;
   logic                gnt_ls;
   logic                any_gnt;
   logic                can_grant;
   logic                busy_done;

   logic                prio_ls;      // 1: LS wins the next contested grant
   logic                owner_ls;     // 1: current transaction belongs to LS
   logic                lat_we;       // current transaction is a store
   logic [2:0]          cnt;

   logic [REG_SIZE-1:0] mem_addr_q;
   logic [REG_SIZE-1:0] mem_wdata_q;
   logic                mem_write_en_q;
   logic                if_rvalid_q;
   logic                ls_rvalid_q;
   logic [REG_SIZE-1:0] if_rdata_q;
   logic [REG_SIZE-1:0] ls_rdata_q;

   // ---------------------------------------------------------------------------
   // Grant decision and next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // one unassigned, which would otherwise infer a latch.
      gnt_if    = 1'b0;
      gnt_ls    = 1'b0;
      state_nxt = state;

      // Grants are suppressed while RST is high: the reset edge would discard
      // the transaction, so the requester must not see it accepted.
      can_grant = ((state == IDLE) || (state == RESP)) && !RST;
      busy_done = (cnt == LAST_CNT);

      if (can_grant) begin
         if (bus.ls_req && (!bus.if_req || prio_ls)) begin
            gnt_ls = 1'b1;
         end else if (bus.if_req) begin
            gnt_if = 1'b1;
         end
      end

      any_gnt = gnt_if || gnt_ls;

      unique case (state)
         IDLE:    if (any_gnt) state_nxt = BUSY;
         BUSY:    if (busy_done) state_nxt = RESP;
         // RESP lasts one cycle; a grant issued here chains straight into BUSY.
         RESP:    state_nxt = any_gnt ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.if_gnt = gnt_if;
   assign bus.ls_gnt = gnt_ls;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values of the previous cycle, independent of block order.
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Transaction registers, RAM pins and responses
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      // NOTE: every register here is reset, not just control state, because
      // all outputs must read 0 after reset and an in-flight transaction is
      // abandoned.
      if (RST) begin
         prio_ls        <= 1'b1;
         owner_ls       <= 1'b0;
         lat_we         <= 1'b0;
         cnt            <= 3'd0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_write_en_q <= 1'b0;
         if_rvalid_q    <= 1'b0;
         ls_rvalid_q    <= 1'b0;
         if_rdata_q     <= '0;
         ls_rdata_q     <= '0;
      end else begin
         // Pulse outputs fall back to 0 unless re-asserted below.
         if_rvalid_q    <= 1'b0;
         ls_rvalid_q    <= 1'b0;
         mem_write_en_q <= 1'b0;

         if (any_gnt) begin
            owner_ls <= gnt_ls;
            lat_we   <= gnt_ls && bus.ls_we;
            cnt      <= 3'd0;
            // The RAM pins are the latched request itself, so the address is
            // already on mem_addr in the first BUSY cycle and stays there
            // through IDLE/RESP until the next grant.
            mem_addr_q <= gnt_ls ? bus.ls_addr : bus.if_addr;
            if (gnt_ls) begin
               mem_wdata_q <= bus.ls_wdata;
            end
            // Write strobe covers only the first BUSY cycle of a store.
            mem_write_en_q <= gnt_ls && bus.ls_we;
            // The pointer moves only when both sides were asking.
            if (bus.if_req && bus.ls_req) begin
               prio_ls <= ~prio_ls;
            end
         end else if (state == BUSY) begin
            if (busy_done) begin
               if (owner_ls) begin
                  ls_rvalid_q <= 1'b1;
                  // A store only acknowledges; ls_rdata keeps the last load.
                  if (!lat_we) begin
                     ls_rdata_q <= bus.mem_rdata;
                  end
               end else begin
                  if_rvalid_q <= 1'b1;
                  if_rdata_q  <= bus.mem_rdata;
               end
            end else begin
               cnt <= cnt + 3'd1;
            end
         end
      end
   end

   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.mem_write_en = mem_write_en_q;
   assign bus.if_rvalid    = if_rvalid_q;
   assign bus.ls_rvalid    = ls_rvalid_q;
   assign bus.if_rdata     = if_rdata_q;
   assign bus.ls_rdata     = ls_rdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Two instances share CLK/RST: dut1 with
// RAM_LAT=1 and dut3 with RAM_LAT=3, each with its own RAM model whose read
// data becomes valid in the RAM_LAT-th cycle the address is shown.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling
// edge of the same cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int W = 8;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   mem_arbiter_if #(.REG_SIZE(W)) bus1 ();
   mem_arbiter_if #(.REG_SIZE(W)) bus3 ();

   mem_arbiter #(.REG_SIZE(W), .RAM_LAT(1)) dut1 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus1.slave)
   );

   mem_arbiter #(.REG_SIZE(W), .RAM_LAT(3)) dut3 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus3.slave)
   );

   // ---------------------------------------------------------------------------
   // RAM models
   // ---------------------------------------------------------------------------
   logic [W-1:0] ram1 [256];
   logic [W-1:0] ram3 [256];
   logic [W-1:0] pipe3_a;
   logic [W-1:0] pipe3_b;
   logic         ram_loaded = 1'b0;

   // RAM_LAT=1: data valid in the same cycle the address is shown.
   assign bus1.mem_rdata = ram1[bus1.mem_addr];
   // RAM_LAT=3: two extra register stages.
   assign bus3.mem_rdata = pipe3_b;

   always @(posedge CLK) begin
      if (!ram_loaded) begin
         ram1[8'h10] <= 8'h3C;
         ram3[8'h20] <= 8'h5A;
         ram_loaded  <= 1'b1;
      end else begin
         if (bus1.mem_write_en) ram1[bus1.mem_addr] <= bus1.mem_wdata;
         if (bus3.mem_write_en) ram3[bus3.mem_addr] <= bus3.mem_wdata;
      end
      pipe3_a <= ram3[bus3.mem_addr];
      pipe3_b <= pipe3_a;
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int total  = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   initial begin
      RST           = 1'b1;
      bus1.if_req   = 1'b0;  bus1.if_addr  = '0;
      bus1.ls_req   = 1'b0;  bus1.ls_we    = 1'b0;
      bus1.ls_addr  = '0;    bus1.ls_wdata = '0;
      bus3.if_req   = 1'b0;  bus3.if_addr  = '0;
      bus3.ls_req   = 1'b0;  bus3.ls_we    = 1'b0;
      bus3.ls_addr  = '0;    bus3.ls_wdata = '0;

      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      sample();
      check("rst if_gnt",       bus1.if_gnt,       1'b0);
      check("rst ls_gnt",       bus1.ls_gnt,       1'b0);
      check("rst if_rvalid",    bus1.if_rvalid,    1'b0);
      check("rst ls_rvalid",    bus1.ls_rvalid,    1'b0);
      check("rst mem_write_en", bus1.mem_write_en, 1'b0);
      check("rst mem_addr",     bus1.mem_addr,     8'h00);
      check("rst if_rdata",     bus1.if_rdata,     8'h00);

      // --- A: IF read 0x10, RAM_LAT=1 -------------------------------------------
      next_cycle(); bus1.if_req = 1'b1; bus1.if_addr = 8'h10;
      sample();
      check("A0 if_gnt", bus1.if_gnt, 1'b1);
      check("A0 ls_gnt", bus1.ls_gnt, 1'b0);
      next_cycle(); bus1.if_req = 1'b0;
      sample();
      check("A1 mem_addr",     bus1.mem_addr,     8'h10);
      check("A1 if_rvalid",    bus1.if_rvalid,    1'b0);
      check("A1 mem_write_en", bus1.mem_write_en, 1'b0);
      next_cycle();
      sample();
      check("A2 if_rvalid", bus1.if_rvalid, 1'b1);
      check("A2 if_rdata",  bus1.if_rdata,  8'h3C);
      check("A2 ls_rvalid", bus1.ls_rvalid, 1'b0);
      check("A2 ls_rdata",  bus1.ls_rdata,  8'h00);
      next_cycle();
      sample();
      check("A3 if_rvalid",     bus1.if_rvalid, 1'b0);
      check("A3 if_rdata hold", bus1.if_rdata,  8'h3C);

      // --- B: LS store 0x05 <= 0xA7, then load 0x05 ------------------------------
      next_cycle(); bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 8'h05; bus1.ls_wdata = 8'hA7;
      sample();
      check("B0 ls_gnt", bus1.ls_gnt, 1'b1);
      check("B0 if_gnt", bus1.if_gnt, 1'b0);
      next_cycle(); bus1.ls_req = 1'b0;
      sample();
      check("B1 mem_write_en", bus1.mem_write_en, 1'b1);
      check("B1 mem_addr",     bus1.mem_addr,     8'h05);
      check("B1 mem_wdata",    bus1.mem_wdata,    8'hA7);
      check("B1 ls_rvalid",    bus1.ls_rvalid,    1'b0);
      next_cycle(); bus1.ls_req = 1'b1; bus1.ls_we = 1'b0;
      sample();
      check("B2 store ack",     bus1.ls_rvalid,    1'b1);
      check("B2 mem_write_en",  bus1.mem_write_en, 1'b0);
      check("B2 ls_rdata keep", bus1.ls_rdata,     8'h00);
      check("B2 load ls_gnt",   bus1.ls_gnt,       1'b1);
      next_cycle(); bus1.ls_req = 1'b0;
      sample();
      check("B3 mem_write_en", bus1.mem_write_en, 1'b0);
      check("B3 ls_rvalid",    bus1.ls_rvalid,    1'b0);
      check("B3 mem_addr",     bus1.mem_addr,     8'h05);
      next_cycle();
      sample();
      check("B4 ls_rvalid", bus1.ls_rvalid, 1'b1);
      check("B4 ls_rdata",  bus1.ls_rdata,  8'hA7);
      check("B4 if_rdata",  bus1.if_rdata,  8'h3C);
      next_cycle();
      sample();
      check("B5 ls_rvalid", bus1.ls_rvalid, 1'b0);

      // --- C: both requesting continuously from reset ---------------------------
      next_cycle(); RST = 1'b1;
      bus1.if_req = 1'b1; bus1.if_addr = 8'h10;
      bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 8'h05;
      sample();
      check("C rst if_gnt", bus1.if_gnt, 1'b0);
      check("C rst ls_gnt", bus1.ls_gnt, 1'b0);
      next_cycle(); RST = 1'b0;
      sample();
      check("C0 ls_gnt",   bus1.ls_gnt,   1'b1);
      check("C0 if_gnt",   bus1.if_gnt,   1'b0);
      check("C0 ls_rdata", bus1.ls_rdata, 8'h00);
      check("C0 if_rdata", bus1.if_rdata, 8'h00);
      check("C0 mem_addr", bus1.mem_addr, 8'h00);
      next_cycle();
      sample();
      check("C1 if_gnt",   bus1.if_gnt,   1'b0);
      check("C1 ls_gnt",   bus1.ls_gnt,   1'b0);
      check("C1 mem_addr", bus1.mem_addr, 8'h05);
      next_cycle();
      sample();
      check("C2 ls_rvalid", bus1.ls_rvalid, 1'b1);
      check("C2 ls_rdata",  bus1.ls_rdata,  8'hA7);
      check("C2 if_gnt",    bus1.if_gnt,    1'b1);
      check("C2 ls_gnt",    bus1.ls_gnt,    1'b0);
      next_cycle();
      sample();
      check("C3 if_gnt",    bus1.if_gnt,    1'b0);
      check("C3 ls_gnt",    bus1.ls_gnt,    1'b0);
      check("C3 mem_addr",  bus1.mem_addr,  8'h10);
      check("C3 ls_rvalid", bus1.ls_rvalid, 1'b0);
      next_cycle();
      sample();
      check("C4 if_rvalid", bus1.if_rvalid, 1'b1);
      check("C4 if_rdata",  bus1.if_rdata,  8'h3C);
      check("C4 ls_gnt",    bus1.ls_gnt,    1'b1);
      check("C4 if_gnt",    bus1.if_gnt,    1'b0);
      next_cycle();
      sample();
      check("C5 ls_gnt", bus1.ls_gnt, 1'b0);
      next_cycle();
      sample();
      check("C6 ls_rvalid", bus1.ls_rvalid, 1'b1);
      check("C6 if_gnt",    bus1.if_gnt,    1'b1);
      check("C6 ls_gnt",    bus1.ls_gnt,    1'b0);
      next_cycle(); bus1.if_req = 1'b0; bus1.ls_req = 1'b0;
      sample();
      next_cycle();
      sample();
      check("C8 if_rvalid", bus1.if_rvalid, 1'b1);
      next_cycle();
      sample();

      // --- E: reset during the first BUSY cycle of an LS load --------------------
      next_cycle(); bus1.if_req = 1'b1; bus1.ls_req = 1'b1;
      sample();
      check("E0 ls_gnt", bus1.ls_gnt, 1'b1);
      check("E0 if_gnt", bus1.if_gnt, 1'b0);
      next_cycle(); RST = 1'b1; bus1.if_req = 1'b0; bus1.ls_req = 1'b0;
      sample();
      check("E1 mem_addr", bus1.mem_addr, 8'h05);
      next_cycle(); RST = 1'b0;
      sample();
      check("E2 ls_rvalid",     bus1.ls_rvalid,    1'b0);
      check("E2 if_rvalid",     bus1.if_rvalid,    1'b0);
      check("E2 mem_addr",      bus1.mem_addr,     8'h00);
      check("E2 mem_wdata",     bus1.mem_wdata,    8'h00);
      check("E2 mem_write_en",  bus1.mem_write_en, 1'b0);
      check("E2 ls_rdata",      bus1.ls_rdata,     8'h00);
      check("E2 if_rdata",      bus1.if_rdata,     8'h00);
      next_cycle();
      sample();
      check("E3 ls_rvalid", bus1.ls_rvalid, 1'b0);
      next_cycle(); bus1.if_req = 1'b1; bus1.ls_req = 1'b1;
      sample();
      check("E4 ls_gnt first", bus1.ls_gnt, 1'b1);
      check("E4 if_gnt",       bus1.if_gnt, 1'b0);
      next_cycle(); bus1.if_req = 1'b0; bus1.ls_req = 1'b0;
      sample();

      // --- D: RAM_LAT=3, IF read 0x20 with LS waiting -----------------------------
      next_cycle(); bus3.if_req = 1'b1; bus3.if_addr = 8'h20;
      sample();
      check("D0 if_gnt", bus3.if_gnt, 1'b1);
      next_cycle(); bus3.if_req = 1'b0;
      bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 8'h20;
      for (int i = 1; i <= 3; i++) begin
         sample();
         check($sformatf("D%0d mem_addr", i),  bus3.mem_addr,  8'h20);
         check($sformatf("D%0d ls_gnt", i),    bus3.ls_gnt,    1'b0);
         check($sformatf("D%0d if_rvalid", i), bus3.if_rvalid, 1'b0);
         if (i < 3) next_cycle();
      end
      next_cycle();
      sample();
      check("D4 if_rvalid", bus3.if_rvalid, 1'b1);
      check("D4 if_rdata",  bus3.if_rdata,  8'h5A);
      check("D4 ls_gnt",    bus3.ls_gnt,    1'b1);
      check("D4 if_gnt",    bus3.if_gnt,    1'b0);
      next_cycle(); bus3.ls_req = 1'b0;
      sample();
      check("D5 if_rvalid", bus3.if_rvalid, 1'b0);
      check("D5 mem_addr",  bus3.mem_addr,  8'h20);
      next_cycle();
      sample();
      next_cycle();
      sample();
      check("D7 ls_rvalid", bus3.ls_rvalid, 1'b0);
      next_cycle();
      sample();
      check("D8 ls_rvalid", bus3.ls_rvalid, 1'b1);
      check("D8 ls_rdata",  bus3.ls_rdata,  8'h5A);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbiter and sequencer sharing the single-port core RAM between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write) of the control unit.
Sits between the control unit and ram inside core.
Owns the RAM address/write-enable/data pins and runs one transaction at a time with a fixed RAM read latency.
Uses round-robin priority on contention.

Parameters:
REG_SIZE, 8, address and data width in bits
RAM_LAT, 1, cycles from address presentation to valid mem_rdata; legal range 1..4

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  REG_SIZE  fetch address
if_gnt  out  1  one-cycle pulse: IF request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  REG_SIZE  fetched data
ls_req  in  1  load/store request; held until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  REG_SIZE  load/store address
ls_wdata  in  REG_SIZE  store data
ls_gnt  out  1  one-cycle pulse: LS request accepted
ls_rvalid  out  1  one-cycle pulse: load data valid or store complete
ls_rdata  out  REG_SIZE  load data
mem_addr  out  REG_SIZE  RAM address
mem_write_en  out  1  RAM write strobe
mem_wdata  out  REG_SIZE  RAM write data
mem_rdata  in  REG_SIZE  RAM read data

Behaviour:
- Reset (RST high at a rising edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The priority pointer is set to favour LS.
  - Any in-flight transaction is abandoned: no rvalid is issued, and mem_write_en is 0 from the next cycle.
- FSM states: IDLE, BUSY, RESP.
- Grant (Mealy):
  - Asserted combinationally in a cycle where the state is IDLE or RESP and at least one req is high.
  - Single requester: that requester is granted.
  - Both requesting: the one favoured by the pointer is granted, and the pointer then flips to favour the other.
  - The pointer changes only on a contested grant.
  - if_gnt and ls_gnt are never high together.
- On a grant edge, the arbiter latches owner, addr, we and wdata, then enters BUSY with a cycle counter of 0.
- BUSY:
  - mem_addr = latched address for all RAM_LAT cycles.
  - mem_wdata = latched wdata.
  - mem_write_en = 1 only in the first BUSY cycle, and only for an LS store.
  - After RAM_LAT cycles: capture mem_rdata (loads and fetches), then go to RESP.
- RESP (exactly one cycle):
  - The owner's rvalid is high. For reads, its rdata holds the captured value.
  - For stores, ls_rvalid is an acknowledge and ls_rdata keeps its previous value.
  - Next state: BUSY if a grant is issued in this cycle, else IDLE.
- Latency: grant in cycle t → rvalid in cycle t+RAM_LAT+1.
- Back-to-back throughput: one transaction per RAM_LAT+1 cycles.
- rdata outputs hold their value until the next read by the same requester.
- mem_addr and mem_wdata hold their last value in IDLE/RESP; mem_write_en is 0 there.
- Requester protocol:
  - addr/we/wdata must be stable while req is high and no gnt has been seen.
  - req may stay high after gnt to request the next transaction.
  - A req dropped before gnt is simply not serviced.
- Simultaneous rvalid for one requester and grant to the other in the same RESP cycle is legal and required.

Test Plan:
- RAM_LAT=1, IF reads addr 0x10 (RAM holds 0x3C) → if_gnt at cycle 0; mem_addr=0x10 in cycle 1; if_rvalid with if_rdata=0x3C in cycle 2; ls_* outputs stay 0.
- LS store addr 0x05 data 0xA7, then LS load 0x05 → mem_write_en high exactly one cycle, ls_rvalid ack 2 cycles after grant; load returns ls_rdata=0xA7.
- if_req and ls_req held high continuously from reset → grants alternate LS, IF, LS, IF; a grant every 2 cycles, each coinciding with the previous rvalid.
- RAM_LAT=3, IF read → rvalid exactly 4 cycles after grant; mem_addr stable for 3 cycles; no second grant before the RESP cycle.
- RST asserted in the first BUSY cycle of an LS load → no ls_rvalid; all outputs 0 the next cycle; a following contested request is granted to LS first.
